ch_sram_sequencer: RTL and testbench
====================================

// Module: ch_sram_sequencer
// PURPOSE
//  Downstream of the checkerboard pattern counter: turns its {data_bit, write_flag, addr} word into SRAM
//  strobes, tracks reads in flight and compares returned data. Owns the counter's cen/rst and the run
//  FSM (start -> clear -> run -> drain -> done). Reports pass/fail, saturating error count, first failing address.
// PARAMETERS
//  ADDR_WIDTH    8  SRAM address width; pattern word is ADDR_WIDTH+2 bits
//  DATA_WIDTH    4  SRAM word width
//  RD_LATENCY    1  cycles from sram_cs&~sram_we sampled to sram_rdata valid (1..4)
//  ERR_CNT_WIDTH 10 error counter width (saturating)
// PORTS
//  clk             in  1              system clock, all flops rising edge
//  rst_n           in  1              asynchronous active-low reset
//  start           in  1              1-cycle request; honoured only in IDLE or DONE
//  pat_in          in  ADDR_WIDTH+2   counter word: [A+1]=data_bit, [A]=write_flag(1=write), [A-1:0]=addr
//  pat_cout        in  1              counter overflow: all 4*2^A operations issued
//  cnt_rst         out 1              synchronous clear to pattern counter
//  cnt_en          out 1              count enable to pattern counter
//  sram_cs         out 1              SRAM chip select (registered)
//  sram_we         out 1              SRAM write enable (registered)
//  sram_addr       out ADDR_WIDTH     SRAM address (registered)
//  sram_wdata      out DATA_WIDTH     SRAM write data (registered)
//  sram_rdata      in  DATA_WIDTH     SRAM read data
//  busy            out 1              high in CLEAR/RUN/DRAIN
//  done            out 1              high in DONE, held until next start
//  fail            out 1              sticky: any mismatch this run
//  err_count       out ERR_CNT_WIDTH  mismatching reads, saturates at all-ones
//  first_fail_addr out ADDR_WIDTH     address of first mismatch; 0 if none
// BEHAVIOUR
//  Reset: FSM=IDLE; every output 0 (sram_cs/we 0, addr/wdata 0, fail/err_count/first_fail_addr 0).
//  Word expansion: exp[i] = data_bit ^ i[0] -> data_bit=0 gives 4'b1010, data_bit=1 gives 4'b0101.
//  FSM:
//   IDLE : start -> CLEAR.
//   CLEAR: 1 cycle; cnt_rst=1; fail/err_count/first_fail_addr cleared; -> RUN.
//   RUN  : cnt_en=1 while pat_cout=0. Each RUN cycle with pat_cout=0 registers pat_in onto SRAM
//          outputs (cs=1, we=write_flag, addr, wdata=expansion) -> 1 cycle latency pat_in -> pins.
//          pat_cout=1: cnt_en=0, no op issued, cs=0 next cycle, -> DRAIN.
//   DRAIN: RD_LATENCY+1 cycles, cs=0, in-flight reads still compared; -> DONE.
//   DONE : done=1; results held; start -> CLEAR (results cleared there).
//  Compare pipeline: each issued read pushes {valid, addr, exp} into a RD_LATENCY+1 deep shift register
//   (1 for output reg + RD_LATENCY); at its end, if valid and sram_rdata!=exp: fail<=1, err_count+=1
//   (stop at max), first_fail_addr captured only when fail was 0. Writes push valid=0.
//  Full run, A=8: 1024 ops (256 W, 256 R, 256 W inv, 256 R inv), 512 compares; CLEAR->DONE = 1+1024+1+(RD_LATENCY+1) cycles.
//  start while busy: ignored. start in same cycle as DRAIN->DONE: ignored (DONE not yet entered).
//  pat_cout=1 on first RUN cycle (counter not cleared): go straight to DRAIN, zero ops, fail=0.
//  rst_n low mid-run: immediate return to IDLE, cs/we drop asynchronously, results cleared.
//  err_count saturation: further mismatches leave count at all-ones; fail stays 1.
// TESTING
//  1 Ideal SRAM model, RD_LATENCY=1, start pulse -> done after 1029 cycles, fail=0, err_count=0, 512 compares.
//  2 Bit 2 of addr 0x37 stuck-at-0 -> fail=1, err_count=1 (only pass with bit2=1 fails), first_fail_addr=0x37.
//  3 Every read returns 4'hF -> err_count=512, first_fail_addr=0x00; ERR_CNT_WIDTH=8 variant -> saturates 255.
//  4 RD_LATENCY=3 with matching delayed model -> fail=0, done 2 cycles later than scenario 1.
//  5 rst_n low at cycle 300 of RUN -> all outputs 0 same cycle; new start -> clean pass identical to scenario 1.
//  6 start pulsed during RUN and DRAIN -> ignored, single done; start in DONE -> results cleared in CLEAR, rerun.

Source files
------------

// File: rtl/ch_sram_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ch_sram_sequencer
// Description : Sequencer that sits downstream of the checkerboard pattern
//               counter. It turns each pattern word {data_bit, write_flag,
//               addr} into registered SRAM strobes, follows every read
//               through a compare pipeline, and checks the returned data
//               against the expanded checkerboard word. It owns the counter's
//               clear/enable and the run FSM
//               (IDLE -> CLEAR -> RUN -> DRAIN -> DONE).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   system clock, every flop on the rising edge
//   rst_n           in   asynchronous active-low reset
//   start           in   one-cycle run request, honoured in IDLE or DONE
//   pat_in          in   counter word: [A+1]=data_bit, [A]=write_flag,
//                        [A-1:0]=addr
//   pat_cout        in   counter overflow, every operation has been issued
//   cnt_rst         out  synchronous clear to the pattern counter
//   cnt_en          out  count enable to the pattern counter
//   sram_cs         out  SRAM chip select (registered)
//   sram_we         out  SRAM write enable (registered)
//   sram_addr       out  SRAM address (registered)
//   sram_wdata      out  SRAM write data (registered)
//   sram_rdata      in   SRAM read data, RD_LATENCY cycles after the read
//   busy            out  high in CLEAR, RUN and DRAIN
//   done            out  high in DONE, held until the next start
//   fail            out  sticky mismatch flag for the current run
//   err_count       out  number of mismatching reads, saturating
//   first_fail_addr out  address of the first mismatch, 0 if none
// ============================================================================
module ch_sram_sequencer #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 4,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH+1:0]    pat_in,
    input  logic                     pat_cout,
    output logic                     cnt_rst,
    output logic                     cnt_en,
    output logic                     sram_cs,
    output logic                     sram_we,
    output logic [ADDR_WIDTH-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_wdata,
    input  logic [DATA_WIDTH-1:0]    sram_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_fail_addr
);

    // One stage for the SRAM output register plus RD_LATENCY stages of
    // SRAM access time: the last stage lines up with sram_rdata.
    localparam int PIPE_DEPTH   = RD_LATENCY + 1;
    // DRAIN must outlast the pipeline so the final read is compared
    // before DONE freezes the results.
    localparam int DRAIN_CYCLES = RD_LATENCY + 1;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0]       DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE    = ERR_CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [DRAIN_W-1:0]        drain_cnt_q, drain_cnt_d;

    logic                      sram_cs_q, sram_cs_d;
    logic                      sram_we_q, sram_we_d;
    logic [ADDR_WIDTH-1:0]     sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0]     sram_wdata_q, sram_wdata_d;

    logic [PIPE_DEPTH-1:0]                 pipe_vld_q, pipe_vld_d;
    logic [PIPE_DEPTH-1:0][ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;
    logic [PIPE_DEPTH-1:0][DATA_WIDTH-1:0] pipe_exp_q, pipe_exp_d;

    logic                      fail_q, fail_d;
    logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]     ffa_q, ffa_d;

    // ------------------------------------------------------------------
    // Pattern word decode and checkerboard expansion
    // ------------------------------------------------------------------
    logic                  pat_data_bit;
    logic                  pat_write;
    logic [ADDR_WIDTH-1:0] pat_addr;
    logic [DATA_WIDTH-1:0] exp_word;

    assign pat_data_bit = pat_in[ADDR_WIDTH+1];
    assign pat_write    = pat_in[ADDR_WIDTH];
    assign pat_addr     = pat_in[ADDR_WIDTH-1:0];

    // Odd bit positions carry the inverse of data_bit, giving alternating
    // columns (data_bit=0 -> ...1010, data_bit=1 -> ...0101).
    always_comb begin
        exp_word = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            exp_word[i] = pat_data_bit ^ i[0];
        end
    end

    // ------------------------------------------------------------------
    // Run FSM: next state and control outputs
    // ------------------------------------------------------------------
    logic issue;          // an operation is taken from the counter this cycle
    logic clear_results;  // wipe fail/err_count/first_fail_addr

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        cnt_rst       = 1'b0;
        cnt_en        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        issue         = 1'b0;
        clear_results = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                busy          = 1'b1;
                cnt_rst       = 1'b1;
                clear_results = 1'b1;
                state_d       = ST_RUN;
            end

            ST_RUN: begin
                busy = 1'b1;
                // An overflowed counter carries no valid operation, so the
                // overflow cycle neither issues nor advances the counter.
                if (pat_cout) begin
                    drain_cnt_d = DRAIN_LAST;
                    state_d     = ST_DRAIN;
                end else begin
                    cnt_en = 1'b1;
                    issue  = 1'b1;
                end
            end

            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // SRAM strobes, compare pipeline and result accumulation
    // ------------------------------------------------------------------
    logic chk_vld;
    logic mismatch;

    assign chk_vld  = pipe_vld_q[PIPE_DEPTH-1];
    assign mismatch = chk_vld && (sram_rdata != pipe_exp_q[PIPE_DEPTH-1]);

    always_comb begin
        // Chip select and write enable are only meaningful on issue cycles;
        // address and data hold their last value to avoid needless toggling.
        sram_cs_d    = issue;
        sram_we_d    = issue & pat_write;
        sram_addr_d  = issue ? pat_addr : sram_addr_q;
        sram_wdata_d = issue ? exp_word : sram_wdata_q;

        // Writes enter the pipeline with valid=0 so that stage alignment
        // is purely positional.
        pipe_vld_d     = '0;
        pipe_addr_d    = '0;
        pipe_exp_d     = '0;
        pipe_vld_d[0]  = issue & ~pat_write;
        pipe_addr_d[0] = pat_addr;
        pipe_exp_d[0]  = exp_word;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            pipe_vld_d[k]  = pipe_vld_q[k-1];
            pipe_addr_d[k] = pipe_addr_q[k-1];
            pipe_exp_d[k]  = pipe_exp_q[k-1];
        end

        fail_d    = fail_q;
        err_cnt_d = err_cnt_q;
        ffa_d     = ffa_q;
        if (clear_results) begin
            fail_d    = 1'b0;
            err_cnt_d = '0;
            ffa_d     = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end
            // fail_q still low means this is the first mismatch of the run.
            if (!fail_q) begin
                ffa_d = pipe_addr_q[PIPE_DEPTH-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            drain_cnt_q  <= '0;
            sram_cs_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            pipe_vld_q   <= '0;
            pipe_addr_q  <= '0;
            pipe_exp_q   <= '0;
            fail_q       <= 1'b0;
            err_cnt_q    <= '0;
            ffa_q        <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            sram_cs_q    <= sram_cs_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_addr_q  <= pipe_addr_d;
            pipe_exp_q   <= pipe_exp_d;
            fail_q       <= fail_d;
            err_cnt_q    <= err_cnt_d;
            ffa_q        <= ffa_d;
        end
    end

    assign sram_cs         = sram_cs_q;
    assign sram_we         = sram_we_q;
    assign sram_addr       = sram_addr_q;
    assign sram_wdata      = sram_wdata_q;
    assign fail            = fail_q;
    assign err_count       = err_cnt_q;
    assign first_fail_addr = ffa_q;

endmodule
`default_nettype wire

// File: tb/tb_ch_sram_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ch_sram_sequencer
// Description : Bench for ch_sram_sequencer. Two instances run side by side
//               (RD_LATENCY=1/ERR_CNT_WIDTH=10 and RD_LATENCY=3/
//               ERR_CNT_WIDTH=8), each with its own pattern counter and SRAM
//               model. Faults are injected into the SRAM read path and the
//               results are compared with a reference computed from the
//               march order (W0, R0, W1, R1 over all addresses).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ch_sram_sequencer;
    localparam int A    = 8;
    localparam int D    = 4;
    localparam int NI   = 2;
    localparam int NOPS = 4 * (1 << A);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    // Fault injection: 0 = ideal, 1 = one stuck bit at one address,
    // 2 = every read returns all ones.
    int           fault_mode = 0;
    logic [A-1:0] fault_addr = '0;
    int           fault_bit  = 0;
    logic         fault_val  = 1'b0;
    logic         cnt_rst_block = 1'b0;  // counter ignores its clear
    logic         clr_stats = 1'b0;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    logic         cnt_rst_o [NI];
    logic         cnt_en_o  [NI];
    logic         cs_o      [NI];
    logic         we_o      [NI];
    logic [A-1:0] addr_o    [NI];
    logic [D-1:0] wdata_o   [NI];
    logic [D-1:0] rdata     [NI];
    logic         busy_o    [NI];
    logic         done_o    [NI];
    logic         fail_o    [NI];
    logic [15:0]  errc      [NI];
    logic [A-1:0] ffa_o     [NI];
    logic [A+1:0] pat       [NI];
    logic         cout      [NI];

    int   done_rises [NI];
    int   done_cyc   [NI];
    int   reads_seen [NI];
    logic done_prev  [NI];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int ECW = (g == 0) ? 10 : 8;
        localparam logic [A+2:0] CNT_ONE = 1;

        logic [ECW-1:0] ec;
        logic [A+2:0]   cnt = '0;
        logic [D-1:0]   mem   [1 << A];
        logic [D-1:0]   rpipe [LAT];
        logic [D-1:0]   rd_now;

        // March order: pass 0 W(0), pass 1 R(0), pass 2 W(1), pass 3 R(1).
        assign pat[g]   = {cnt[A+1], ~cnt[A], cnt[A-1:0]};
        assign cout[g]  = cnt[A+2];
        assign errc[g]  = 16'(ec);
        assign rdata[g] = rpipe[LAT-1];

        always @(posedge clk) begin
            if (cnt_rst_o[g] && !cnt_rst_block) cnt <= '0;
            else if (cnt_en_o[g] && !cnt[A+2])  cnt <= cnt + CNT_ONE;
        end

        always_comb begin
            rd_now = mem[addr_o[g]];
            if (fault_mode == 2)
                rd_now = '1;
            else if (fault_mode == 1 && addr_o[g] == fault_addr)
                rd_now[fault_bit] = fault_val;
        end

        always @(posedge clk) begin
            if (cs_o[g] && we_o[g]) mem[addr_o[g]] <= wdata_o[g];
            rpipe[0] <= rd_now;
            for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
        end

        ch_sram_sequencer #(
            .ADDR_WIDTH    (A),
            .DATA_WIDTH    (D),
            .RD_LATENCY    (LAT),
            .ERR_CNT_WIDTH (ECW)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start),
            .pat_in          (pat[g]),
            .pat_cout        (cout[g]),
            .cnt_rst         (cnt_rst_o[g]),
            .cnt_en          (cnt_en_o[g]),
            .sram_cs         (cs_o[g]),
            .sram_we         (we_o[g]),
            .sram_addr       (addr_o[g]),
            .sram_wdata      (wdata_o[g]),
            .sram_rdata      (rdata[g]),
            .busy            (busy_o[g]),
            .done            (done_o[g]),
            .fail            (fail_o[g]),
            .err_count       (ec),
            .first_fail_addr (ffa_o[g])
        );
    end

    // Per-instance observation: done rising edges, their cycle, reads on pins.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (clr_stats) begin
                done_rises[i] <= 0;
                done_cyc[i]   <= 0;
                reads_seen[i] <= 0;
            end else begin
                if (done_o[i] && !done_prev[i]) begin
                    done_rises[i] <= done_rises[i] + 1;
                    done_cyc[i]   <= cyc;
                end
                if (cs_o[i] && !we_o[i]) reads_seen[i] <= reads_seen[i] + 1;
            end
            done_prev[i] <= done_o[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected results from the march: only the two read passes compare,
    // pass R0 expects 4'hA and pass R1 expects 4'h5 at every address.
    function automatic void ref_model(input int ecw, output int err, output int first,
                                      output logic fl);
        int n;
        logic [D-1:0] expw;
        logic [D-1:0] got;
        n = 0;
        first = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int a = 0; a < (1 << A); a++) begin
                expw = (pass == 0) ? 4'hA : 4'h5;
                got  = expw;
                if (fault_mode == 2) got = 4'hF;
                else if (fault_mode == 1 && a == int'(fault_addr)) got[fault_bit] = fault_val;
                if (got != expw) begin
                    if (n == 0) first = a;
                    n++;
                end
            end
        end
        fl  = (n != 0);
        err = (n > (1 << ecw) - 1) ? (1 << ecw) - 1 : n;
    endfunction

    task automatic chk_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s/%0d/ctl", tag, i),
                {cs_o[i], we_o[i], busy_o[i], done_o[i], fail_o[i], cnt_rst_o[i], cnt_en_o[i]}, 0);
            chk($sformatf("%s/%0d/data", tag, i), {addr_o[i], wdata_o[i], ffa_o[i], errc[i]}, 0);
        end
    endtask

    task automatic run_once(input string tag, input bit noisy, input int nops);
        int sc;
        bit finished;
        int e, f, lat, ecw;
        logic fl;
        @(posedge clk); #1;
        clr_stats = 1'b1;
        start     = 1'b1;
        sc        = cyc;
        finished  = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk); #1;
            clr_stats = 1'b0;
            // Extra pulses land in RUN and in DRAIN, the last one on the
            // DRAIN->DONE cycle of the latency-1 instance.
            start = noisy && (k == 500 || k == 1027 || k == 1028);
            if (k == 2) begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("%s/%0d/cleared", tag, i),
                        {busy_o[i], done_o[i], fail_o[i], errc[i], ffa_o[i]},
                        {1'b1, 1'b0, 1'b0, 16'd0, 8'd0});
                end
            end
            if (done_o[0] && done_o[1]) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "/finished"}, 64'(finished), 1);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            lat = (i == 0) ? 1 : 3;
            ecw = (i == 0) ? 10 : 8;
            ref_model(ecw, e, f, fl);
            chk($sformatf("%s/%0d/latency", tag, i), done_cyc[i] - sc, nops + lat + 4);
            chk($sformatf("%s/%0d/done_rises", tag, i), done_rises[i], 1);
            chk($sformatf("%s/%0d/reads", tag, i), reads_seen[i], nops / 2);
            chk($sformatf("%s/%0d/busy_done", tag, i), {busy_o[i], done_o[i]}, 2'b01);
            chk($sformatf("%s/%0d/fail", tag, i), fail_o[i], (nops == 0) ? 1'b0 : fl);
            chk($sformatf("%s/%0d/err_count", tag, i), errc[i], (nops == 0) ? 0 : e);
            chk($sformatf("%s/%0d/first_fail", tag, i), ffa_o[i], (nops == 0) ? 0 : f);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Ideal SRAM
        fault_mode = 0;
        run_once("ideal", 0, NOPS);

        // Bit 2 of address 0x37 stuck at 0: only the R1 pass fails there
        fault_mode = 1; fault_addr = 8'h37; fault_bit = 2; fault_val = 1'b0;
        run_once("stuck37", 0, NOPS);

        // Every read returns all ones: 512 errors, saturating at 255 on ECW=8
        fault_mode = 2;
        run_once("all_ones", 0, NOPS);

        // Restart from DONE after a failing run, with stray starts mid-run
        fault_mode = 0;
        run_once("rerun_noisy", 1, NOPS);

        // Random single stuck bits
        for (int r = 0; r < 3; r++) begin
            fault_mode = 1;
            fault_addr = A'($urandom_range(0, (1 << A) - 1));
            fault_bit  = int'($urandom_range(0, D - 1));
            fault_val  = 1'($urandom_range(0, 1));
            run_once($sformatf("rand%0d", r), 0, NOPS);
        end

        // Asynchronous reset in the middle of RUN while errors accumulate
        fault_mode = 2;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (301) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("midrun_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        fault_mode = 0;
        run_once("after_rst", 0, NOPS);

        // Counter left overflowed (its clear ignored): straight to DRAIN
        cnt_rst_block = 1'b1;
        run_once("cout_first", 0, 0);
        cnt_rst_block = 1'b0;

        run_once("final", 0, NOPS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
